sfilt_mc: RTL and testbench

- Parametrised, multi-channel successor to the serial filter block: a command-driven multiply-accumulate engine with NCH independent accumulators, selected per transaction.
- Fully pipelined: accepts one command every cycle on any channel mix. Results retire in order at a fixed latency.
- Adds over the single-channel block:
  - configurable data/accumulator widths;
  - configurable multiplier pipeline depth;
  - same-channel hazard forwarding at any spacing;
  - optional output saturation with an overflow flag.
- Sits between the sample/coefficient feeder and the downstream output FIFO.

---
 rtl/sfilt_mc.sv | 131 +++++++++++++
 tb/tb_sfilt_mc.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfilt_mc.sv
// Multi-channel pipelined multiply-accumulate filter engine: NCH accumulators,
// one command per cycle, in-order results at fixed latency MUL_STAGES+2.
module sfilt_mc #(
   parameter int DW         = 32,
   parameter int ACC_W      = 64,
   parameter int CHW        = 2,
   parameter int MUL_STAGES = 2,
   parameter int SAT        = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           pushin,
   input  logic [1:0]     cmd,
   input  logic [CHW-1:0] ch,
   input  logic [DW-1:0]  q,
   input  logic [DW-1:0]  h,
   output logic           pushout,
   output logic [DW-1:0]  z,
   output logic [CHW-1:0] zch,
   output logic           ovf
);

   localparam int NCH = 1 << CHW;
   localparam int M   = MUL_STAGES;
   localparam int PW  = 2 * DW;

   // index 0 is the input register, index M feeds the execute stage
   logic [M:0]            vld_pipe;
   logic [M:0][1:0]       cmd_pipe;
   logic [M:0][CHW-1:0]   ch_pipe;
   logic [M:1][6:0]       sh_pipe;
   logic [M:1][PW-1:0]    prod_pipe;
   logic [DW-1:0]         q_r, h_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe  <= '0;
         cmd_pipe  <= '0;
         ch_pipe   <= '0;
         sh_pipe   <= '0;
         prod_pipe <= '0;
         q_r       <= '0;
         h_r       <= '0;
      end else begin
         vld_pipe <= {vld_pipe[M-1:0], pushin};
         if (pushin) begin
            cmd_pipe[0] <= cmd;
            ch_pipe[0]  <= ch;
            q_r         <= q;
            h_r         <= h;
         end
         for (int i = 1; i <= M; i++) begin
            cmd_pipe[i] <= cmd_pipe[i-1];
            ch_pipe[i]  <= ch_pipe[i-1];
         end
         sh_pipe[1]   <= h_r[6:0];
         prod_pipe[1] <= PW'($signed(q_r)) * PW'($signed(h_r));
         for (int i = 2; i <= M; i++) begin
            sh_pipe[i]   <= sh_pipe[i-1];
            prod_pipe[i] <= prod_pipe[i-1];
         end
      end
   end

   logic signed [ACC_W-1:0] acc [NCH];
   logic signed [ACC_W-1:0] a, p_ext, shr, nxt;
   logic [6:0]              s;
   logic                    rnd, fits;
   logic [DW-1:0]           zc;

   // Execute reads the live accumulator, which already holds the previous
   // command's write-back, so same-channel commands chain at any spacing.
   always_comb begin
      s     = sh_pipe[M];
      a     = acc[ch_pipe[M]];
      p_ext = ACC_W'($signed(prod_pipe[M]));
      if (int'(s) >= ACC_W) begin
         shr = {ACC_W{a[ACC_W-1]}};
         rnd = a[ACC_W-1];
      end else begin
         shr = a >>> s;
         rnd = (s != 7'd0) && (|(a & (ACC_W'(1) << (s - 7'd1))));
      end
      case (cmd_pipe[M])
         2'd0:    nxt = p_ext;
         2'd1:    nxt = a + p_ext;
         2'd2:    nxt = shr + ACC_W'(rnd);
         default: nxt = '0;
      endcase
      fits = (&a[ACC_W-1:DW-1]) || (~|a[ACC_W-1:DW-1]);
      zc   = a[DW-1:0];
      if (SAT != 0 && !fits)
         zc = a[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
   end

   logic           x_vld, x_ovf;
   logic [DW-1:0]  x_z;
   logic [CHW-1:0] x_ch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) acc[i] <= '0;
         x_vld   <= 1'b0;
         x_ovf   <= 1'b0;
         x_z     <= '0;
         x_ch    <= '0;
         pushout <= 1'b0;
         z       <= '0;
         zch     <= '0;
         ovf     <= 1'b0;
      end else begin
         x_vld <= vld_pipe[M] && (cmd_pipe[M] == 2'd3);
         if (vld_pipe[M]) begin
            acc[ch_pipe[M]] <= nxt;
            if (cmd_pipe[M] == 2'd3) begin
               x_z   <= zc;
               x_ch  <= ch_pipe[M];
               x_ovf <= (SAT != 0) && !fits;
            end
         end
         // output stage: results hold until the next send
         pushout <= x_vld;
         if (x_vld) begin
            z   <= x_z;
            zch <= x_ch;
            ovf <= x_ovf;
         end
      end
   end

endmodule

// File: tb/tb_sfilt_mc.sv
// Bench for sfilt_mc: a SAT=0 and a SAT=1 instance share stimulus; results are
// scored against a longint accumulator model with timestamps.
module tb_sfilt_mc;
   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst, pushin;
   logic [1:0]  cmd, ch;
   logic [31:0] q, h;
   logic        po0, ov0, po1, ov1;
   logic [31:0] z0, z1;
   logic [1:0]  zc0, zc1;

   sfilt_mc #(.SAT(0)) dut (
      .clk(clk), .rst(rst), .pushin(pushin), .cmd(cmd), .ch(ch), .q(q), .h(h),
      .pushout(po0), .z(z0), .zch(zc0), .ovf(ov0));
   sfilt_mc #(.SAT(1)) dut_sat (
      .clk(clk), .rst(rst), .pushin(pushin), .cmd(cmd), .ch(ch), .q(q), .h(h),
      .pushout(po1), .z(z1), .zch(zc1), .ovf(ov1));

   typedef struct packed {
      logic [63:0] t;
      logic        p0;
      logic [31:0] z0;
      logic [1:0]  c0;
      logic        o0;
      logic        p1;
      logic [31:0] z1;
      logic [1:0]  c1;
      logic        o1;
   } ent_t;

   ent_t   expq[$], obsq[$];
   ent_t   mon_e;
   longint racc [4];
   int     checks = 0, errors = 0;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (po0 || po1) begin
         mon_e.t  = 64'($time);
         mon_e.p0 = po0; mon_e.z0 = z0; mon_e.c0 = zc0; mon_e.o0 = ov0;
         mon_e.p1 = po1; mon_e.z1 = z1; mon_e.c1 = zc1; mon_e.o1 = ov1;
         obsq.push_back(mon_e);
      end
   end

   // drive one command and apply the accumulator rules to the model
   task automatic issue(input logic [1:0] c, input logic [1:0] n,
                        input logic [31:0] qv, input logic [31:0] hv);
      longint a, p;
      int     s;
      ent_t   e;
      pushin = 1'b1; cmd = c; ch = n; q = qv; h = hv;
      @(posedge clk);
      a = racc[n];
      p = longint'($signed(qv)) * longint'($signed(hv));
      case (c)
         2'd0: a = p;
         2'd1: a = a + p;
         2'd2: begin
            s = int'(hv[6:0]);
            if (s >= 64) a = 0;
            else if (s > 0) a = (a >>> s) + ((a >>> (s - 1)) & 64'sd1);
         end
         default: begin
            e = '0;
            e.t = 64'($time) + 64'(LAT * 10 + 5);
            e.p0 = 1'b1; e.z0 = a[31:0]; e.c0 = n; e.o0 = 1'b0;
            e.p1 = 1'b1; e.c1 = n;
            if (a > 64'sd2147483647) begin
               e.z1 = 32'h7fffffff; e.o1 = 1'b1;
            end else if (a < -64'sd2147483648) begin
               e.z1 = 32'h80000000; e.o1 = 1'b1;
            end else begin
               e.z1 = a[31:0]; e.o1 = 1'b0;
            end
            expq.push_back(e);
            a = 0;
         end
      endcase
      racc[n] = a;
      #1 pushin = 1'b0;
   endtask

   task automatic tick(input int n);
      pushin = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; pushin = 1'b0; cmd = '0; ch = '0; q = '0; h = '0;
      for (int i = 0; i < 4; i++) racc[i] = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      tick(2);
      checks++;
      if ({po0, z0, zc0, ov0} !== 36'd0) begin
         errors++; $display("FAIL reset_sat0: got %h want 0", {po0, z0, zc0, ov0});
      end
      checks++;
      if ({po1, z1, zc1, ov1} !== 36'd0) begin
         errors++; $display("FAIL reset_sat1: got %h want 0", {po1, z1, zc1, ov1});
      end
   endtask

   task automatic test_basic;
      issue(2'd0, 2'd0, 32'd3, 32'd4);
      issue(2'd1, 2'd0, 32'd5, 32'd6);
      issue(2'd3, 2'd0, 32'd0, 32'd0);
      tick(LAT + 3);
      checks++;
      if (obsq.size() != expq.size()) begin
         errors++; $display("FAIL basic_count: got %0d want %0d", obsq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
         checks++;
         if (obsq[i] !== expq[i]) begin
            errors++; $display("FAIL basic[%0d]: got %h want %h", i, obsq[i], expq[i]);
         end
      end
      if (obsq.size() > 0) begin
         checks++;
         if ({obsq[0].z0, obsq[0].c0, obsq[0].o0} !== {32'd42, 2'd0, 1'b0}) begin
            errors++; $display("FAIL basic_z42: got z=%0d zch=%0d ovf=%0d want 42/0/0",
                               obsq[0].z0, obsq[0].c0, obsq[0].o0);
         end
      end
      obsq.delete(); expq.delete();
   endtask

   task automatic test_back_to_back;
      issue(2'd0, 2'd1, -32'sd2, 32'd7);
      issue(2'd1, 2'd1, 32'd1, 32'd1);
      issue(2'd1, 2'd1, 32'd10, 32'd10);
      issue(2'd2, 2'd1, 32'd0, 32'd2);
      issue(2'd3, 2'd1, 32'd0, 32'd0);
      tick(LAT + 3);
      checks++;
      if (obsq.size() != expq.size()) begin
         errors++; $display("FAIL b2b_count: got %0d want %0d", obsq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
         checks++;
         if (obsq[i] !== expq[i]) begin
            errors++; $display("FAIL b2b[%0d]: got %h want %h", i, obsq[i], expq[i]);
         end
      end
      if (obsq.size() > 0) begin
         checks++;
         if (obsq[0].z0 !== 32'd22 || obsq[0].z1 !== 32'd22) begin
            errors++; $display("FAIL b2b_z22: got %0d/%0d want 22", obsq[0].z0, obsq[0].z1);
         end
      end
      obsq.delete(); expq.delete();
   endtask

   task automatic test_round;
      issue(2'd0, 2'd2, -32'sd5, 32'd1);
      issue(2'd2, 2'd2, 32'd0, 32'd1);
      issue(2'd3, 2'd2, 32'd0, 32'd0);
      issue(2'd0, 2'd2, -32'sd1, 32'd1);
      issue(2'd2, 2'd2, 32'd0, 32'd100);
      issue(2'd3, 2'd2, 32'd0, 32'd0);
      tick(LAT + 3);
      checks++;
      if (obsq.size() != expq.size()) begin
         errors++; $display("FAIL round_count: got %0d want %0d", obsq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
         checks++;
         if (obsq[i] !== expq[i]) begin
            errors++; $display("FAIL round[%0d]: got %h want %h", i, obsq[i], expq[i]);
         end
      end
      if (obsq.size() > 1) begin
         checks++;
         if (obsq[0].z0 !== 32'hfffffffe || obsq[1].z0 !== 32'd0) begin
            errors++; $display("FAIL round_vals: got %h,%h want fffffffe,0", obsq[0].z0, obsq[1].z0);
         end
      end
      obsq.delete(); expq.delete();
   endtask

   task automatic test_interleave;
      for (int k = 0; k < 6; k++) begin
         issue((k == 0) ? 2'd0 : 2'd1, 2'd0, 32'($urandom_range(0, 200)) - 32'd100, 32'($urandom_range(0, 50)));
         issue((k == 0) ? 2'd0 : 2'd1, 2'd3, 32'($urandom), 32'($urandom_range(0, 1000)));
      end
      issue(2'd3, 2'd0, 32'd0, 32'd0);
      issue(2'd3, 2'd3, 32'd0, 32'd0);
      issue(2'd3, 2'd0, 32'd0, 32'd0);
      tick(LAT + 3);
      checks++;
      if (obsq.size() != expq.size()) begin
         errors++; $display("FAIL ilv_count: got %0d want %0d", obsq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
         checks++;
         if (obsq[i] !== expq[i]) begin
            errors++; $display("FAIL ilv[%0d]: got %h want %h", i, obsq[i], expq[i]);
         end
      end
      if (obsq.size() > 2) begin
         checks++;
         if ({obsq[0].c0, obsq[1].c0, obsq[2].c0, obsq[2].z0} !== {2'd0, 2'd3, 2'd0, 32'd0}) begin
            errors++; $display("FAIL ilv_order: got ch %0d,%0d,%0d z=%h want 0,3,0 z=0",
                               obsq[0].c0, obsq[1].c0, obsq[2].c0, obsq[2].z0);
         end
      end
      obsq.delete(); expq.delete();
   endtask

   task automatic test_saturation;
      issue(2'd0, 2'd1, 32'h7fffffff, 32'd4);
      issue(2'd3, 2'd1, 32'd0, 32'd0);
      issue(2'd0, 2'd1, 32'h7fffffff, 32'hfffffffc);
      issue(2'd3, 2'd1, 32'd0, 32'd0);
      tick(LAT + 3);
      checks++;
      if (obsq.size() != expq.size()) begin
         errors++; $display("FAIL sat_count: got %0d want %0d", obsq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
         checks++;
         if (obsq[i] !== expq[i]) begin
            errors++; $display("FAIL sat[%0d]: got %h want %h", i, obsq[i], expq[i]);
         end
      end
      if (obsq.size() > 1) begin
         checks++;
         if ({obsq[0].z0, obsq[0].o0, obsq[0].z1, obsq[0].o1} !== {32'hfffffffc, 1'b0, 32'h7fffffff, 1'b1}) begin
            errors++; $display("FAIL sat_pos: got %h/%b %h/%b want fffffffc/0 7fffffff/1",
                               obsq[0].z0, obsq[0].o0, obsq[0].z1, obsq[0].o1);
         end
         checks++;
         if ({obsq[1].z0, obsq[1].o0, obsq[1].z1, obsq[1].o1} !== {32'h00000004, 1'b0, 32'h80000000, 1'b1}) begin
            errors++; $display("FAIL sat_neg: got %h/%b %h/%b want 00000004/0 80000000/1",
                               obsq[1].z0, obsq[1].o0, obsq[1].z1, obsq[1].o1);
         end
      end
      obsq.delete(); expq.delete();
   endtask

   task automatic test_reset_mid;
      issue(2'd0, 2'd0, 32'd9, 32'd9);
      issue(2'd3, 2'd0, 32'd0, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 4; i++) racc[i] = 0;
      expq.delete();
      tick(2);
      rst = 1'b0;
      tick(LAT + 2);
      checks++;
      if (obsq.size() != 0 || po0 !== 1'b0 || z0 !== 32'd0 || z1 !== 32'd0) begin
         errors++; $display("FAIL rstmid_quiet: got %0d pushouts z=%h/%h want none, z=0",
                            obsq.size(), z0, z1);
      end
      obsq.delete();
      issue(2'd3, 2'd0, 32'd0, 32'd0);
      tick(LAT + 3);
      checks++;
      if (obsq.size() != expq.size()) begin
         errors++; $display("FAIL rstmid_count: got %0d want %0d", obsq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
         checks++;
         if (obsq[i] !== expq[i] || obsq[i].z0 !== 32'd0) begin
            errors++; $display("FAIL rstmid[%0d]: got %h want %h", i, obsq[i], expq[i]);
         end
      end
      obsq.delete(); expq.delete();
   endtask

   task automatic test_random;
      logic [31:0] qv, hv;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 9) < 2) tick(1);
         else begin
            qv = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 40)) - 32'd20;
            hv = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40));
            issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), qv, hv);
         end
      end
      for (int c = 0; c < 4; c++) issue(2'd3, 2'(c), 32'd0, 32'd0);
      tick(LAT + 3);
      checks++;
      if (obsq.size() != expq.size()) begin
         errors++; $display("FAIL rand_count: got %0d want %0d", obsq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
         checks++;
         if (obsq[i] !== expq[i]) begin
            errors++; $display("FAIL rand[%0d]: got %h want %h", i, obsq[i], expq[i]);
         end
      end
      obsq.delete(); expq.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_round();
      test_interleave();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
